// File: rtl/overlay_pkg.sv
// Shared constants, mode encoding and byte-strobe helper for the overlay blend block.
package overlay_pkg;

    localparam int OFF_W = 3;

    localparam logic [OFF_W-1:0] OFF_CTRL   = 3'd0;
    localparam logic [OFF_W-1:0] OFF_X0     = 3'd1;
    localparam logic [OFF_W-1:0] OFF_Y0     = 3'd2;
    localparam logic [OFF_W-1:0] OFF_W_REG  = 3'd3;
    localparam logic [OFF_W-1:0] OFF_H_REG  = 3'd4;
    localparam logic [OFF_W-1:0] OFF_COLOR  = 3'd5;
    localparam logic [OFF_W-1:0] OFF_ALPHA  = 3'd6;
    localparam logic [OFF_W-1:0] OFF_STATUS = 3'd7;

    typedef enum logic [1:0] {
        MODE_PASS    = 2'd0,
        MODE_FILL    = 2'd1,
        MODE_BLEND   = 2'd2,
        MODE_OUTLINE = 2'd3
    } mode_e;

    localparam int         ALPHA_MAX = 256;
    localparam logic [1:0] RESP_OKAY = 2'b00;

    function automatic logic [31:0] merge_strb(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/overlay_axis_blend_if.sv
// AXI4-Lite control bundle and AXI4-Stream video bundle used by the overlay block.
interface overlay_axil_if #(parameter int ADDR_W = 5);
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

interface overlay_axis_if #(parameter int DATA_W = 24);
    logic [DATA_W-1:0] tdata;
    logic              tuser;
    logic              tlast;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, tuser, tlast, tvalid, input tready);
    modport slave  (input tdata, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/overlay_axil_regs.sv
// AXI4-Lite register file: handshakes, byte strobes, alpha saturation, frame counter and W1C sof_err.
module overlay_axil_regs
    import overlay_pkg::*;
#(
    parameter int CH_W    = 8,
    parameter int COORD_W = 12,
    parameter int ADDR_W  = 5
) (
    input  logic               ACLK,
    input  logic               ARESETN,
    overlay_axil_if.slave      axil,
    input  logic               sof_evt,
    input  logic               sof_err_evt,
    output mode_e              mode,
    output logic [COORD_W-1:0] x0,
    output logic [COORD_W-1:0] y0,
    output logic [COORD_W-1:0] w,
    output logic [COORD_W-1:0] h,
    output logic [3*CH_W-1:0]  color,
    output logic [8:0]         alpha
);
    localparam int N_WORDS = 2 ** OFF_W;

    logic [OFF_W-1:0] wr_off;
    logic [OFF_W-1:0] rd_off;
    logic             wr_mapped;
    logic             rd_mapped;
    logic             wr_fire;
    logic             rd_fire;
    logic             status_clr;
    logic [15:0]      frame_cnt;
    logic             sof_err;
    logic [31:0]      reg_view [N_WORDS];
    logic [31:0]      wr_word;

    assign wr_off    = axil.awaddr[OFF_W+1:2];
    assign rd_off    = axil.araddr[OFF_W+1:2];
    assign wr_mapped = (axil.awaddr >> (OFF_W + 2)) == '0;
    assign rd_mapped = (axil.araddr >> (OFF_W + 2)) == '0;
    assign wr_fire   = axil.awready && axil.awvalid && axil.wvalid;
    assign rd_fire   = axil.arready && axil.arvalid;
    assign status_clr = wr_fire && wr_mapped && (wr_off == OFF_STATUS)
                        && axil.wstrb[2] && axil.wdata[16];

    always_comb begin
        // NOTE: every word is defaulted first so unmapped entries never infer a latch.
        for (int i = 0; i < N_WORDS; i++) reg_view[i] = '0;
        reg_view[OFF_CTRL]   = 32'(mode);
        reg_view[OFF_X0]     = 32'(x0);
        reg_view[OFF_Y0]     = 32'(y0);
        reg_view[OFF_W_REG]  = 32'(w);
        reg_view[OFF_H_REG]  = 32'(h);
        reg_view[OFF_COLOR]  = 32'(color);
        reg_view[OFF_ALPHA]  = 32'(alpha);
        reg_view[OFF_STATUS] = {15'b0, sof_err, frame_cnt};
        wr_word = merge_strb(reg_view[wr_off], axil.wdata, axil.wstrb);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            axil.awready <= 1'b0;
            axil.wready  <= 1'b0;
            axil.bvalid  <= 1'b0;
            axil.bresp   <= RESP_OKAY;
            axil.arready <= 1'b0;
            axil.rvalid  <= 1'b0;
            axil.rresp   <= RESP_OKAY;
            axil.rdata   <= '0;
            mode         <= MODE_PASS;
            x0           <= '0;
            y0           <= '0;
            w            <= '0;
            h            <= '0;
            color        <= '0;
            alpha        <= '0;
            frame_cnt    <= '0;
            sof_err      <= 1'b0;
        end else begin
            // NOTE: non-blocking updates keep every register sampling pre-edge values.
            if (axil.bvalid && axil.bready) axil.bvalid <= 1'b0;
            if (wr_fire) begin
                axil.awready <= 1'b0;
                axil.wready  <= 1'b0;
                axil.bvalid  <= 1'b1;
                axil.bresp   <= RESP_OKAY;
            end else if (axil.awvalid && axil.wvalid && !axil.bvalid && !axil.awready) begin
                axil.awready <= 1'b1;
                axil.wready  <= 1'b1;
            end

            if (wr_fire && wr_mapped) begin
                case (wr_off)
                    OFF_CTRL:  mode  <= mode_e'(wr_word[1:0]);
                    OFF_X0:    x0    <= wr_word[COORD_W-1:0];
                    OFF_Y0:    y0    <= wr_word[COORD_W-1:0];
                    OFF_W_REG: w     <= wr_word[COORD_W-1:0];
                    OFF_H_REG: h     <= wr_word[COORD_W-1:0];
                    OFF_COLOR: color <= wr_word[3*CH_W-1:0];
                    OFF_ALPHA: alpha <= (wr_word > 32'(ALPHA_MAX)) ? 9'(ALPHA_MAX) : wr_word[8:0];
                    default:   ;
                endcase
            end

            // A new error in the same cycle as a clear wins so it is never lost.
            if (sof_err_evt)     sof_err <= 1'b1;
            else if (status_clr) sof_err <= 1'b0;
            if (sof_evt) frame_cnt <= frame_cnt + 16'd1;

            if (axil.rvalid && axil.rready) axil.rvalid <= 1'b0;
            if (rd_fire) begin
                axil.arready <= 1'b0;
                axil.rvalid  <= 1'b1;
                axil.rresp   <= RESP_OKAY;
                axil.rdata   <= rd_mapped ? reg_view[rd_off] : '0;
            end else if (axil.arvalid && !axil.rvalid && !axil.arready) begin
                axil.arready <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/overlay_axis_blend.sv
// In-line AXI4-Stream overlay: frame-shadowed config, x/y tracking, fill/blend/outline, one output register.
module overlay_axis_blend
    import overlay_pkg::*;
#(
    parameter int CH_W     = 8,
    parameter int COORD_W  = 12,
    parameter int ADDR_W   = 5,
    parameter int BORDER_W = 2
) (
    input  logic            ACLK,
    input  logic            ARESETN,
    overlay_axil_if.slave   s_axil,
    overlay_axis_if.slave   s_axis,
    overlay_axis_if.master  m_axis
);
    localparam int PIX_W = 3 * CH_W;
    localparam int EXT_W = COORD_W + 1;

    mode_e              cfg_mode, act_mode, e_mode;
    logic [COORD_W-1:0] cfg_x0, cfg_y0, cfg_w, cfg_h;
    logic [COORD_W-1:0] act_x0, act_y0, act_w, act_h;
    logic [COORD_W-1:0] e_x0, e_y0, e_w, e_h;
    logic [PIX_W-1:0]   cfg_color, act_color, e_color;
    logic [8:0]         cfg_alpha, act_alpha, e_alpha;

    logic               in_fire, sof_evt, sof_err_evt;
    logic [COORD_W-1:0] x_cnt, y_cnt, x_eff, y_eff, x_inc, y_inc;
    logic [EXT_W-1:0]   xe, ye, x0e, y0e, x_end, y_end;
    logic               in_region, on_border;
    logic [PIX_W-1:0]   blended, pix_out;

    overlay_axil_regs #(
        .CH_W    (CH_W),
        .COORD_W (COORD_W),
        .ADDR_W  (ADDR_W)
    ) u_regs (
        .ACLK        (ACLK),
        .ARESETN     (ARESETN),
        .axil        (s_axil),
        .sof_evt     (sof_evt),
        .sof_err_evt (sof_err_evt),
        .mode        (cfg_mode),
        .x0          (cfg_x0),
        .y0          (cfg_y0),
        .w           (cfg_w),
        .h           (cfg_h),
        .color       (cfg_color),
        .alpha       (cfg_alpha)
    );

    function automatic logic [CH_W-1:0] blend_ch(input logic [8:0]      a,
                                                 input logic [CH_W-1:0] c,
                                                 input logic [CH_W-1:0] p);
        logic [CH_W+8:0] acc;
        acc = (CH_W+9)'(a) * (CH_W+9)'(c)
            + (CH_W+9)'(9'(ALPHA_MAX) - a) * (CH_W+9)'(p);
        return acc[CH_W+7:8];
    endfunction

    assign s_axis.tready = ARESETN && (!m_axis.tvalid || m_axis.tready);
    assign in_fire       = s_axis.tvalid && s_axis.tready;
    assign sof_evt       = in_fire && s_axis.tuser;
    assign sof_err_evt   = sof_evt && (x_cnt != '0);

    // The SOF beat itself already uses the freshly shadowed config and position (0,0).
    assign e_mode  = s_axis.tuser ? cfg_mode  : act_mode;
    assign e_x0    = s_axis.tuser ? cfg_x0    : act_x0;
    assign e_y0    = s_axis.tuser ? cfg_y0    : act_y0;
    assign e_w     = s_axis.tuser ? cfg_w     : act_w;
    assign e_h     = s_axis.tuser ? cfg_h     : act_h;
    assign e_color = s_axis.tuser ? cfg_color : act_color;
    assign e_alpha = s_axis.tuser ? cfg_alpha : act_alpha;
    assign x_eff   = s_axis.tuser ? '0 : x_cnt;
    assign y_eff   = s_axis.tuser ? '0 : y_cnt;
    assign x_inc   = (x_eff == '1) ? x_eff : x_eff + 1'b1;
    assign y_inc   = (y_eff == '1) ? y_eff : y_eff + 1'b1;

    always_comb begin
        xe    = EXT_W'(x_eff);
        ye    = EXT_W'(y_eff);
        x0e   = EXT_W'(e_x0);
        y0e   = EXT_W'(e_y0);
        x_end = EXT_W'(e_x0) + EXT_W'(e_w);
        y_end = EXT_W'(e_y0) + EXT_W'(e_h);
        in_region = (xe >= x0e) && (xe < x_end) && (ye >= y0e) && (ye < y_end);
        on_border = (xe < x0e + EXT_W'(BORDER_W)) || (xe + EXT_W'(BORDER_W) >= x_end)
                 || (ye < y0e + EXT_W'(BORDER_W)) || (ye + EXT_W'(BORDER_W) >= y_end);

        for (int i = 0; i < 3; i++) begin
            blended[i*CH_W +: CH_W] = blend_ch(e_alpha, e_color[i*CH_W +: CH_W],
                                               s_axis.tdata[i*CH_W +: CH_W]);
        end

        pix_out = s_axis.tdata;
        case (e_mode)
            MODE_FILL:    if (in_region) pix_out = e_color;
            MODE_BLEND:   if (in_region) pix_out = blended;
            MODE_OUTLINE: if (in_region && on_border) pix_out = e_color;
            default:      pix_out = s_axis.tdata;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            x_cnt         <= '0;
            y_cnt         <= '0;
            act_mode      <= MODE_PASS;
            act_x0        <= '0;
            act_y0        <= '0;
            act_w         <= '0;
            act_h         <= '0;
            act_color     <= '0;
            act_alpha     <= '0;
            m_axis.tdata  <= '0;
            m_axis.tuser  <= 1'b0;
            m_axis.tlast  <= 1'b0;
            m_axis.tvalid <= 1'b0;
        end else if (in_fire) begin
            if (s_axis.tuser) begin
                act_mode  <= cfg_mode;
                act_x0    <= cfg_x0;
                act_y0    <= cfg_y0;
                act_w     <= cfg_w;
                act_h     <= cfg_h;
                act_color <= cfg_color;
                act_alpha <= cfg_alpha;
            end
            if (s_axis.tlast) begin
                x_cnt <= '0;
                y_cnt <= y_inc;
            end else begin
                x_cnt <= x_inc;
                y_cnt <= y_eff;
            end
            m_axis.tdata  <= pix_out;
            m_axis.tuser  <= s_axis.tuser;
            m_axis.tlast  <= s_axis.tlast;
            m_axis.tvalid <= 1'b1;
        end else if (m_axis.tready) begin
            m_axis.tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_overlay_axis_blend.sv
// Randomised self-checking bench for overlay_axis_blend against a per-pixel reference model.
`timescale 1ns/1ps
module tb_overlay_axis_blend;
    import overlay_pkg::*;

    localparam int CH_W = 8, COORD_W = 12, ADDR_W = 5, BORDER_W = 2, PIX_W = 24;

    typedef struct {
        logic [PIX_W-1:0] data;
        bit               sof;
        bit               last;
    } beat_t;

    typedef struct {
        int               mode, x0, y0, w, h;
        logic [PIX_W-1:0] color;
        int               alpha;
    } cfg_t;

    logic ACLK = 1'b0;
    logic ARESETN = 1'b0;
    always #5 ACLK = ~ACLK;

    overlay_axil_if #(.ADDR_W(ADDR_W)) axil ();
    overlay_axis_if #(.DATA_W(PIX_W))  s_axis ();
    overlay_axis_if #(.DATA_W(PIX_W))  m_axis ();

    overlay_axis_blend #(
        .CH_W(CH_W), .COORD_W(COORD_W), .ADDR_W(ADDR_W), .BORDER_W(BORDER_W)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .s_axil(axil), .s_axis(s_axis), .m_axis(m_axis)
    );

    int    n_cmp = 0;
    int    n_err = 0;
    int    frames_sent = 0;
    beat_t in_q[$];
    beat_t exp_q[$];

    function automatic logic [PIX_W-1:0] model_pixel(input cfg_t c, input int x, input int y,
                                                     input logic [PIX_W-1:0] p);
        bit               inside_r, border;
        int               a, cc, pc;
        logic [PIX_W-1:0] r;
        inside_r = (x >= c.x0) && (x < c.x0 + c.w) && (y >= c.y0) && (y < c.y0 + c.h);
        border = inside_r && ((x - c.x0) < BORDER_W || (c.x0 + c.w - 1 - x) < BORDER_W ||
                              (y - c.y0) < BORDER_W || (c.y0 + c.h - 1 - y) < BORDER_W);
        a = (c.alpha > 256) ? 256 : c.alpha;
        r = p;
        case (c.mode)
            1: if (inside_r) r = c.color;
            2: if (inside_r) begin
                for (int i = 0; i < 3; i++) begin
                    cc = int'(c.color[8*i +: 8]);
                    pc = int'(p[8*i +: 8]);
                    r[8*i +: 8] = 8'((a * cc + (256 - a) * pc) / 256);
                end
            end
            3: if (border) r = c.color;
            default: r = p;
        endcase
        return r;
    endfunction

    task automatic axil_write(input int off, input logic [31:0] data, input logic [3:0] strb,
                              output logic [1:0] resp);
        bit ok;
        ok = 0;
        resp = 2'bxx;
        axil.awaddr = ADDR_W'(off * 4);
        axil.wdata = data;
        axil.wstrb = strb;
        axil.awvalid = 1'b1;
        axil.wvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge ACLK);
            if (axil.awready && axil.wready) begin ok = 1; break; end
        end
        @(posedge ACLK); #1;
        axil.awvalid = 1'b0;
        axil.wvalid = 1'b0;
        if (ok) begin
            ok = 0;
            for (int i = 0; i < 50; i++) begin
                @(negedge ACLK);
                if (axil.bvalid) begin ok = 1; resp = axil.bresp; break; end
            end
            @(posedge ACLK); #1;
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL axil_write_timeout off %0d: no handshake within bound", off);
        end
    endtask

    task automatic axil_read(input int off, output logic [31:0] data, output logic [1:0] resp);
        bit ok;
        ok = 0;
        data = 'x;
        resp = 2'bxx;
        axil.araddr = ADDR_W'(off * 4);
        axil.arvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge ACLK);
            if (axil.arready) begin ok = 1; break; end
        end
        @(posedge ACLK); #1;
        axil.arvalid = 1'b0;
        if (ok) begin
            ok = 0;
            for (int i = 0; i < 50; i++) begin
                @(negedge ACLK);
                if (axil.rvalid) begin ok = 1; data = axil.rdata; resp = axil.rresp; break; end
            end
            @(posedge ACLK); #1;
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL axil_read_timeout off %0d: no handshake within bound", off);
        end
    endtask

    task automatic write_cfg(input cfg_t c);
        logic [1:0] r;
        axil_write(0, 32'(c.mode), 4'hF, r);
        axil_write(1, 32'(c.x0), 4'hF, r);
        axil_write(2, 32'(c.y0), 4'hF, r);
        axil_write(3, 32'(c.w), 4'hF, r);
        axil_write(4, 32'(c.h), 4'hF, r);
        axil_write(5, 32'(c.color), 4'hF, r);
        axil_write(6, 32'(c.alpha), 4'hF, r);
    endtask

    // Queue one frame (or its first n_beats beats when n_beats >= 0) plus its expected output.
    task automatic add_frame(input cfg_t c, input int fw, input int fh, input int n_beats,
                             input bit rand_px, input logic [PIX_W-1:0] fixed_px);
        beat_t b, e;
        int    k;
        k = 0;
        frames_sent++;
        for (int y = 0; y < fh; y++) begin
            for (int x = 0; x < fw; x++) begin
                if (n_beats >= 0 && k >= n_beats) return;
                b.data = rand_px ? PIX_W'($urandom) : fixed_px;
                b.sof  = (x == 0 && y == 0);
                b.last = (x == fw - 1);
                e = b;
                e.data = model_pixel(c, x, y, b.data);
                in_q.push_back(b);
                exp_q.push_back(e);
                k++;
            end
        end
    endtask

    task automatic run_stream(input int ready_pct, input bit check_lat, input int max_cycles);
        int               cyc;
        int               in_cyc[$];
        int               t_in;
        bit               stalled;
        logic [PIX_W+1:0] held;
        beat_t            e;
        cyc = 0;
        stalled = 0;
        held = '0;
        while ((in_q.size() > 0 || exp_q.size() > 0) && cyc < max_cycles) begin
            if (in_q.size() > 0) begin
                s_axis.tdata = in_q[0].data;
                s_axis.tuser = in_q[0].sof;
                s_axis.tlast = in_q[0].last;
                s_axis.tvalid = 1'b1;
            end else begin
                s_axis.tvalid = 1'b0;
            end
            m_axis.tready = ($urandom_range(99) < ready_pct);
            @(negedge ACLK);
            if (stalled) begin
                n_cmp++;
                if ({m_axis.tvalid, m_axis.tdata, m_axis.tuser, m_axis.tlast} !== {1'b1, held}) begin
                    n_err++;
                    $display("FAIL stall_hold cyc %0d: got v=%b %h want held %h", cyc,
                             m_axis.tvalid, {m_axis.tdata, m_axis.tuser, m_axis.tlast}, held);
                end
            end
            if (m_axis.tvalid && m_axis.tready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL extra_beat cyc %0d: got %h want no beat", cyc, m_axis.tdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_axis.tdata, m_axis.tuser, m_axis.tlast} !== {e.data, e.sof, e.last}) begin
                        n_err++;
                        $display("FAIL out_beat cyc %0d: got %h sof %b last %b want %h sof %b last %b",
                                 cyc, m_axis.tdata, m_axis.tuser, m_axis.tlast, e.data, e.sof, e.last);
                    end
                    if (check_lat && in_cyc.size() > 0) begin
                        t_in = in_cyc.pop_front();
                        n_cmp++;
                        if (cyc !== t_in + 1) begin
                            n_err++;
                            $display("FAIL latency: got out cyc %0d want %0d", cyc, t_in + 1);
                        end
                    end
                end
            end
            stalled = m_axis.tvalid && !m_axis.tready;
            held = {m_axis.tdata, m_axis.tuser, m_axis.tlast};
            if (s_axis.tvalid && s_axis.tready) begin
                void'(in_q.pop_front());
                in_cyc.push_back(cyc);
            end
            @(posedge ACLK); #1;
            cyc++;
        end
        s_axis.tvalid = 1'b0;
        m_axis.tready = 1'b1;
        if (in_q.size() > 0 || exp_q.size() > 0) begin
            n_cmp++; n_err++;
            $display("FAIL stream_timeout: got %0d in / %0d out pending want 0", in_q.size(), exp_q.size());
        end
        in_q.delete();
        exp_q.delete();
    endtask

    task automatic check_status(input string name, input logic [31:0] want);
        logic [31:0] d;
        logic [1:0]  r;
        axil_read(7, d, r);
        n_cmp++;
        if (d !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, d, want);
        end
    endtask

    task automatic check_regs_zero(input string name);
        logic [31:0] d;
        logic [1:0]  r;
        for (int i = 0; i < 8; i++) begin
            axil_read(i, d, r);
            n_cmp++;
            if (d !== 32'h0) begin
                n_err++;
                $display("FAIL %s off %0d: got %h want 00000000", name, i, d);
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge ACLK);
        #1;
        n_cmp++;
        if ({m_axis.tvalid, s_axis.tready, axil.awready, axil.wready, axil.bvalid,
             axil.arready, axil.rvalid, m_axis.tdata, axil.rdata, axil.bresp, axil.rresp} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got mv=%b sr=%b aw=%b b=%b ar=%b r=%b tdata=%h rdata=%h want all 0",
                     m_axis.tvalid, s_axis.tready, axil.awready, axil.bvalid, axil.arready,
                     axil.rvalid, m_axis.tdata, axil.rdata);
        end
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(posedge ACLK); #1;
        check_regs_zero("reset_regs");
    endtask

    task automatic test_regs();
        logic [31:0] wv[4];
        logic [31:0] ev[4];
        logic [31:0] d;
        logic [1:0]  r;
        wv = '{32'h0101FFFF, 32'hABCD0001, 32'hDEAD0011, 32'hBEEF0011};
        ev = '{32'h00000FFF, 32'h00000001, 32'h00000011, 32'h00000011};
        for (int i = 0; i < 4; i++) begin
            axil_write(i + 1, wv[i], 4'hF, r);
            n_cmp++;
            if (r !== RESP_OKAY) begin n_err++; $display("FAIL bresp off %0d: got %b want 00", i + 1, r); end
        end
        for (int i = 0; i < 4; i++) begin
            axil_read(i + 1, d, r);
            n_cmp++;
            if (d !== ev[i] || r !== RESP_OKAY) begin
                n_err++;
                $display("FAIL readback off %0d: got %h resp %b want %h resp 00", i + 1, d, r, ev[i]);
            end
        end
        axil_write(6, 32'h3FF, 4'hF, r);
        axil_read(6, d, r);
        n_cmp++;
        if (d !== 32'h100) begin n_err++; $display("FAIL alpha_sat: got %h want 00000100", d); end
        axil_write(0, 32'hFFFFFFFF, 4'hF, r);
        axil_read(0, d, r);
        n_cmp++;
        if (d !== 32'h3) begin n_err++; $display("FAIL ctrl_mask: got %h want 00000003", d); end
        axil_write(5, 32'h00112233, 4'hF, r);
        axil_write(5, 32'hAABBCCDD, 4'b0100, r);
        axil_read(5, d, r);
        n_cmp++;
        if (d !== 32'h00BB2233) begin n_err++; $display("FAIL wstrb_merge: got %h want 00BB2233", d); end
        axil_write(7, 32'h0000FFFF, 4'hF, r);
        check_status("status_ro", 32'h0);
    endtask

    task automatic test_pass();
        cfg_t c;
        c = '{mode: 0, x0: 0, y0: 0, w: 8, h: 4, color: 24'h123456, alpha: 0};
        write_cfg(c);
        add_frame(c, 8, 4, -1, 0, 24'h010203);
        run_stream(100, 1, 200);
        check_status("frame_count_pass", 32'(frames_sent));
    endtask

    task automatic test_fill();
        cfg_t c;
        c = '{mode: 1, x0: 2, y0: 1, w: 3, h: 2, color: 24'hFF0000, alpha: 0};
        write_cfg(c);
        add_frame(c, 8, 4, -1, 1, '0);
        run_stream(100, 1, 200);
    endtask

    task automatic test_blend();
        cfg_t c;
        int   alphas[3];
        alphas = '{128, 0, 256};
        for (int i = 0; i < 3; i++) begin
            c = '{mode: 2, x0: 1, y0: 1, w: 4, h: 2, color: 24'hFFFFFF, alpha: alphas[i]};
            write_cfg(c);
            add_frame(c, 6, 4, -1, 0, 24'h000000);
            run_stream(100, 0, 200);
        end
        c = '{mode: 3, x0: 1, y0: 0, w: 6, h: 5, color: 24'h00FF00, alpha: 0};
        write_cfg(c);
        add_frame(c, 8, 6, -1, 1, '0);
        run_stream(100, 0, 300);
    endtask

    task automatic test_backpressure();
        cfg_t       c_old, c_new;
        logic [1:0] r;
        c_old = '{mode: 1, x0: 1, y0: 1, w: 5, h: 2, color: 24'h0000FF, alpha: 0};
        c_new = c_old;
        c_new.color = 24'hC0FFEE;
        write_cfg(c_old);
        add_frame(c_old, 8, 4, -1, 1, '0);
        add_frame(c_new, 8, 4, -1, 1, '0);
        add_frame(c_new, 8, 4, -1, 1, '0);
        fork
            run_stream(50, 0, 2000);
            begin
                repeat (10) @(posedge ACLK);
                #1;
                axil_write(5, 32'hC0FFEE, 4'hF, r);
            end
        join
    endtask

    task automatic test_random();
        cfg_t c;
        int   fw, fh;
        for (int it = 0; it < 8; it++) begin
            fw = $urandom_range(3, 10);
            fh = $urandom_range(2, 6);
            c.mode  = $urandom_range(3);
            c.x0    = $urandom_range(0, fw);
            c.y0    = $urandom_range(0, fh);
            c.w     = $urandom_range(0, fw);
            c.h     = $urandom_range(0, fh);
            c.color = PIX_W'($urandom);
            c.alpha = $urandom_range(0, 300);
            write_cfg(c);
            add_frame(c, fw, fh, -1, 1, '0);
            run_stream($urandom_range(30, 100), 0, 1000);
        end
    endtask

    task automatic test_sof_err();
        cfg_t       c;
        logic [1:0] r;
        c = '{mode: 1, x0: 0, y0: 0, w: 2, h: 1, color: 24'hABCDEF, alpha: 0};
        write_cfg(c);
        add_frame(c, 8, 4, 5, 1, '0);
        add_frame(c, 8, 4, -1, 1, '0);
        run_stream(100, 0, 300);
        check_status("sof_err_set", {15'b0, 1'b1, 16'(frames_sent)});
        axil_write(7, 32'h00010000, 4'b0100, r);
        check_status("sof_err_clear", {16'b0, 16'(frames_sent)});
    endtask

    task automatic test_reset_mid();
        cfg_t c;
        m_axis.tready = 1'b0;
        s_axis.tdata = 24'h5A5A5A;
        s_axis.tuser = 1'b1;
        s_axis.tlast = 1'b0;
        s_axis.tvalid = 1'b1;
        @(posedge ACLK); #1;
        s_axis.tvalid = 1'b0;
        @(negedge ACLK);
        n_cmp++;
        if (m_axis.tvalid !== 1'b1) begin n_err++; $display("FAIL pre_reset_valid: got %b want 1", m_axis.tvalid); end
        #2;
        ARESETN = 1'b0;
        #1;
        n_cmp++;
        if ({m_axis.tvalid, s_axis.tready} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_mid_valid: got tvalid %b tready %b want 0 0", m_axis.tvalid, s_axis.tready);
        end
        @(posedge ACLK);
        @(negedge ACLK);
        ARESETN = 1'b1;
        m_axis.tready = 1'b1;
        frames_sent = 0;
        @(posedge ACLK); #1;
        check_regs_zero("reset_mid_regs");
        c = '{mode: 0, x0: 0, y0: 0, w: 0, h: 0, color: 24'h0, alpha: 0};
        add_frame(c, 4, 2, -1, 1, '0);
        run_stream(100, 1, 100);
        check_status("frame_count_after_reset", 32'h1);
    endtask

    initial begin
        axil.awaddr = '0; axil.awvalid = 1'b0; axil.wdata = '0; axil.wstrb = '0; axil.wvalid = 1'b0;
        axil.bready = 1'b1; axil.araddr = '0; axil.arvalid = 1'b0; axil.rready = 1'b1;
        s_axis.tdata = '0; s_axis.tuser = 1'b0; s_axis.tlast = 1'b0; s_axis.tvalid = 1'b0;
        m_axis.tready = 1'b1;

        test_reset();
        test_regs();
        test_pass();
        test_fill();
        test_blend();
        test_backpressure();
        test_random();
        test_sof_err();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/overlay_axis_blend.md
Name: overlay_axis_blend

Overview:
Parametrised successor to the 4-register overlay IP. An AXI4-Lite register file configures a rectangular overlay region, colour, alpha and mode. The block is applied in-line to an AXI4-Stream video path (TUSER[0]=SOF, TLAST=EOL). It tracks x/y pixel position and fills, alpha-blends or outlines the region, with one registered pipeline stage. It sits between the camera-side stream source and the display DMA in the filter pipeline.

Parameters:
CH_W, 8, bits per colour channel; pixel is 3 channels, TDATA width 3*CH_W
COORD_W, 12, width of x/y counters and rectangle fields
ADDR_W, 5, AXI-Lite address width (8 word registers)
BORDER_W, 2, outline thickness in pixels for mode 3

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous active-low reset
s_axil_awaddr/awvalid/awready  in/in/out  ADDR_W/1/1  AXI-Lite write address
s_axil_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data
s_axil_bresp/bvalid/bready  out/out/in  2/1/1  write response
s_axil_araddr/arvalid/arready  in/in/out  ADDR_W/1/1  read address
s_axil_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data
s_axis_tdata/tuser/tlast/tvalid/tready  in/in/in/in/out  3*CH_W/1/1/1/1  video in
m_axis_tdata/tuser/tlast/tvalid/tready  out/out/out/out/in  3*CH_W/1/1/1/1  video out

Behaviour:
- Registers (word offset): 0 CTRL[1:0]=mode (0 pass, 1 fill, 2 blend, 3 outline); 1 X0[COORD_W-1:0]; 2 Y0; 3 W; 4 H; 5 COLOR[3*CH_W-1:0]; 6 ALPHA[8:0]; 7 STATUS (RO: [15:0] frame count, [16] sticky sof_err, W1C).
- Reset values: all registers 0, all valid/ready outputs 0, resp 0, rdata 0, tdata 0.
- AXI-Lite write: accepted only when awvalid and wvalid are both high and bvalid=0. awready=wready pulse for 1 cycle. bvalid rises the next cycle and holds until bready. WSTRB is honoured per byte. Writes to unmapped offsets and to STATUS (except the bit-16 W1C) are ignored; bresp is always OKAY.
- AXI-Lite read: arready pulses when arvalid and rvalid=0. rvalid rises the next cycle with rdata and holds until rready. Unmapped offsets read 0.
- Shadowing: X0/Y0/W/H/COLOR/ALPHA/mode are copied into active registers on each accepted SOF beat and apply from that beat onward. Mid-frame writes take effect at the next frame.
- ALPHA is saturated to 256 on write; values above 256 are stored as 256.
- Position: on an accepted beat with SOF, x=0 and y=0. Otherwise, after an accepted TLAST beat, x=0 and y++; after other accepted beats, x++. Counters saturate at all-ones.
- sof_err: set when SOF is accepted with x!=0. The frame still restarts. frame count increments on every accepted SOF and wraps at 16 bits.
- In-region: X0<=x<X0+W and Y0<=y<Y0+H, computed at COORD_W+1 bits so there is no wrap. W=0 or H=0 means no region.
- Outline (mode 3): pixel is in-region and within BORDER_W of any edge.
- Blend, per channel: out=(a*c + (256-a)*p) >> 8, with a 9-bit and intermediate CH_W+9 bits. a=0 yields p; a=256 yields c.
- Fill/outline replace the pixel with COLOR. Out-of-region pixels and mode 0 pass unchanged.
- Pipeline: one output register. s_axis_tready = !m_axis_tvalid || m_axis_tready. Latency is 1 cycle, with full throughput under continuous tready. tuser/tlast pass through aligned with the data. The output is held stable while stalled.
- Reset mid-frame clears the output valid immediately (dropping any beat in flight) and zeroes the counters. The next frame requires SOF.

Decomposition:
- Package overlay_pkg: register offset constants, mode enum (MODE_PASS/FILL/BLEND/OUTLINE), ALPHA_MAX=256, RESP_OKAY.
- Sub-module overlay_axil_regs: AXI-Lite handshake, register file, W1C and alpha saturation.
- Top: shadowing, counters, region test, blend datapath, output register.

Test Plan:
- Write 0x0101FFFF, 0xABCD0001, 0xDEAD0011, 0xBEEF0011 to offsets 1–4, then read back -> values masked to COORD_W bits, bresp/rresp=OKAY. Write ALPHA=0x3FF -> reads 0x100.
- Mode 0, 8x4 frame of pixel 0x010203, continuous tready -> identical output stream, 1-cycle latency, SOF/TLAST aligned, STATUS frame count=1.
- Mode 1, X0=2, Y0=1, W=3, H=2, COLOR=0xFF0000 -> pixels (2..4, 1..2) become 0xFF0000, all others unchanged.
- Mode 2, ALPHA=128, COLOR=0xFFFFFF, pixel 0x000000 -> in-region output 0x7F7F7F. With ALPHA=0 the pixel is unchanged; with ALPHA=256 it becomes 0xFFFFFF.
- Random m_axis_tready backpressure (50%) over 3 frames -> no beat lost or duplicated, data stable while stalled. A COLOR write mid-frame-1 first appears in frame 2.
- SOF injected at x=5 -> STATUS[16]=1 and counters restart. Writing 1 to bit 16 clears it. Asserting ARESETN low mid-frame -> m_axis_tvalid=0 the same cycle, registers read 0 after release.
